// File: rtl/stopwatch_pkg.sv
// Shared types, constants and BCD helpers for the stopwatch controller.
// Holds the FSM state enum, mode bit positions and the BCD step function.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    LOAD,
    PAUSED,
    RUN,
    DONE
  } state_t;

  localparam int MODE_DIR_BIT = 1;
  localparam int MODE_PRE_BIT = 0;

  localparam logic [3:0]  BCD_MAX = 4'd9;
  localparam logic [15:0] TERM_UP = 16'h9999;
  localparam logic [15:0] TERM_DN = 16'h0000;

  function automatic logic [3:0] bcd_clamp(
    input logic [3:0] n
  );
    return (n > BCD_MAX) ? BCD_MAX : n;
  endfunction

  function automatic logic [15:0] term_val(
    input logic down
  );
    return down ? TERM_DN : TERM_UP;
  endfunction

  // One BCD step with ripple: up wraps 9->0
  // and carries, down wraps 0->9 and borrows.
  function automatic logic [15:0] bcd_step(
    input logic [15:0] v,
    input logic        down
  );
    logic [15:0] res;
    logic        c;
    logic [3:0]  d;
    res = v;
    c   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = v[i*4 +: 4];
      if (c) begin
        if (!down) begin
          if (d >= BCD_MAX) begin
            res[i*4 +: 4] = 4'd0;
          end else begin
            res[i*4 +: 4] = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            res[i*4 +: 4] = BCD_MAX;
          end else begin
            res[i*4 +: 4] = d - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Board-side bundle of the stopwatch: buttons, switches, digits, status.
// master drives buttons/switches; slave is the controller. Macro: STOPWATCH_LAP_EN.
interface stopwatch_ctrl_if;

  logic       s;
  logic       r;
  logic [1:0] mode;
  logic [7:0] preval;
`ifdef STOPWATCH_LAP_EN
  logic       lap;
`endif
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic       running;
  logic       done;
  logic       tick;

  modport master (
`ifdef STOPWATCH_LAP_EN
    output lap,
`endif
    output s, r, mode, preval,
    input  digit0, digit1,
    input  digit2, digit3,
    input  running, done, tick
  );

  modport slave (
`ifdef STOPWATCH_LAP_EN
    input  lap,
`endif
    input  s, r, mode, preval,
    output digit0, digit1,
    output digit2, digit3,
    output running, done, tick
  );

endinterface

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, rise pulse.
// Ports: clk, reset (sync, high), btn (raw), pulse (1 cycle on press).
module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  localparam int CW =
    (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX =
    CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  // The accepted level flips only once the
  // synchronised input has disagreed with it
  // for DEB_CYCLES consecutive samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      pulse  <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CMAX) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
        pulse   <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// 4-digit BCD stopwatch/timer sequencer: buttons, tick, up/down count.
// Ports: clk, reset (sync, high), bus (stopwatch_ctrl_if.slave). Macro: STOPWATCH_LAP_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV   = 1000000,
  parameter int DEB_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  stopwatch_ctrl_if.slave  bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX =
    PW'(TICK_DIV - 1);

  state_t        state_q;
  logic [15:0]   cnt_q;
  logic [PW-1:0] presc_q;
  logic          tick_q;
  logic          dir_q;

  logic          start_p;
  logic          clear_p;

  logic          wrap;
  logic [PW-1:0] presc_inc;
  logic [15:0]   stepped;
  logic [15:0]   term;
  logic          done_hit;

  logic          ld_dn;
  logic [7:0]    ld_lo;
  logic [7:0]    ld_hi;
  logic [15:0]   disp;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb_s (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.s),
    .pulse (start_p)
  );

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb_r (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.r),
    .pulse (clear_p)
  );

  assign wrap      = (presc_q == PMAX);
  assign presc_inc = wrap ? '0
                   : presc_q + PW'(1);
  assign stepped   = bcd_step(cnt_q, dir_q);
  assign term      = term_val(dir_q);
  assign done_hit  = wrap && (stepped == term);

  assign ld_dn = bus.mode[MODE_DIR_BIT];
  assign ld_lo = ld_dn ? 8'h99 : 8'h00;
  assign ld_hi = bus.mode[MODE_PRE_BIT]
    ? {bcd_clamp(bus.preval[7:4]),
       bcd_clamp(bus.preval[3:0])}
    : ld_lo;

  // tick_q is loaded with the condition for the
  // coming cycle, so it is high exactly while the
  // prescaler sits at TICK_DIV-1 in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      unique case (state_q)
        LOAD: begin
          dir_q   <= ld_dn;
          cnt_q   <= {ld_hi, ld_lo};
          presc_q <= '0;
          state_q <= PAUSED;
        end
        PAUSED: begin
          if (clear_p) begin
            state_q <= LOAD;
          end else if (start_p) begin
            if (cnt_q == term) begin
              state_q <= DONE;
            end else begin
              state_q <= RUN;
              tick_q  <= wrap;
            end
          end
        end
        RUN: begin
          if (clear_p) begin
            state_q <= LOAD;
          end else begin
            presc_q <= presc_inc;
            if (wrap) cnt_q <= stepped;
            if (done_hit) begin
              state_q <= DONE;
            end else if (start_p) begin
              state_q <= PAUSED;
            end else begin
              tick_q <= (presc_inc == PMAX);
            end
          end
        end
        DONE: begin
          if (clear_p) state_q <= LOAD;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic        lap_p;
  logic        lap_hold_q;
  logic [15:0] lap_q;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb_lap (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.lap),
    .pulse (lap_p)
  );

  // Hold drops on reload, clear or terminal
  // count; lap_p toggles it only while running.
  always_ff @(posedge clk) begin
    if (reset) begin
      lap_hold_q <= 1'b0;
      lap_q      <= '0;
    end else if (state_q == LOAD || clear_p) begin
      lap_hold_q <= 1'b0;
    end else if (state_q == RUN) begin
      if (done_hit) begin
        lap_hold_q <= 1'b0;
      end else if (lap_p) begin
        lap_hold_q <= !lap_hold_q;
        if (!lap_hold_q) lap_q <= cnt_q;
      end
    end
  end

  assign disp = lap_hold_q ? lap_q : cnt_q;
`else
  assign disp = cnt_q;
`endif

  assign bus.digit0  = disp[3:0];
  assign bus.digit1  = disp[7:4];
  assign bus.digit2  = disp[11:8];
  assign bus.digit3  = disp[15:12];
  assign bus.running = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.tick    = tick_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, DEB_CYCLES=2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_stopwatch_ctrl;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;
  int   nt;

  stopwatch_ctrl_if bus();

  stopwatch_ctrl #(
    .TICK_DIV   (4),
    .DEB_CYCLES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  function automatic logic [31:0] dig();
    return {16'h0, bus.digit3, bus.digit2,
            bus.digit1, bus.digit0};
  endfunction

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] res;
    res = '0;
    res[15:12] = 4'((v / 1000) % 10);
    res[11:8]  = 4'((v / 100) % 10);
    res[7:4]   = 4'((v / 10) % 10);
    res[3:0]   = 4'(v % 10);
    return res;
  endfunction

  task automatic step();
    @(negedge clk);
    if (bus.tick) nt++;
  endtask

  task automatic press(
    input logic ps,
    input logic pr,
    input int   len
  );
    bus.s = ps;
    bus.r = pr;
    repeat (len) step();
    bus.s = 1'b0;
    bus.r = 1'b0;
  endtask

  task automatic wait_run(
    input logic  v,
    input string tag
  );
    for (int i = 0; i < 40 && bus.running !== v; i++)
      step();
    check(tag, bus.running, v);
  endtask

  task automatic run_ticks(input int n);
    int got;
    got = 0;
    for (int i = 0; i < n * 4 + 20 && got < n; i++) begin
      step();
      if (bus.tick) got++;
    end
    check("ticks", got, n);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    nt = 0;
    bus.s = 1'b0;
    bus.r = 1'b0;
    bus.mode = 2'b00;
    bus.preval = 8'h00;
`ifdef STOPWATCH_LAP_EN
    bus.lap = 1'b0;
`endif
    reset = 1'b1;
    repeat (3) step();
    check("rst_dig", dig(), 32'h0000);
    check("rst_run", bus.running, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_tick", bus.tick, 1'b0);
    reset = 1'b0;
    repeat (3) step();
    check("load0", dig(), 32'h0000);
    check("idle_run", bus.running, 1'b0);

    // count up 40 ticks, tick every 4 cycles
    nt = 0;
    press(1'b1, 1'b0, 3);
    wait_run(1'b1, "run_up");
    check("tick_lat0", bus.tick, 1'b0);
    repeat (3) step();
    check("tick_lat3", bus.tick, 1'b1);
    repeat (4) step();
    check("tick_gap", bus.tick, 1'b1);
    run_ticks(38);
    step();
    check("cnt40", dig(), 32'h0040);

    // too-short press is rejected
    press(1'b1, 1'b0, 1);
    repeat (8) step();
    check("glitch", bus.running, 1'b1);

    // pause with prescaler landing on 2
    for (int i = 0; i < 10 && !bus.tick; i++) step();
    check("sync_tick", bus.tick, 1'b1);
    repeat (2) step();
    bus.s = 1'b1;
    repeat (3) step();
    bus.s = 1'b0;
    wait_run(1'b0, "pause");
    check("pause_dig", dig(), to_bcd(nt));
    repeat (10) step();
    check("one_pulse", bus.running, 1'b0);
    check("pause_hold", dig(), to_bcd(nt));
    press(1'b1, 1'b0, 3);
    wait_run(1'b1, "resume");
    check("res_t0", bus.tick, 1'b0);
    step();
    check("res_t1", bus.tick, 1'b1);

    // preset with clamp
    bus.mode = 2'b01;
    bus.preval = 8'hA3;
    press(1'b0, 1'b1, 3);
    repeat (8) step();
    check("pre_dig", dig(), 32'h9300);
    check("pre_run", bus.running, 1'b0);
    check("pre_done", bus.done, 1'b0);

    // count down, preval ignored
    bus.mode = 2'b10;
    bus.preval = 8'h55;
    press(1'b0, 1'b1, 3);
    repeat (8) step();
    check("dn_load", dig(), 32'h9999);
    press(1'b1, 1'b0, 3);
    wait_run(1'b1, "dn_run");
    run_ticks(1);
    step();
    check("dn_step", dig(), 32'h9998);

    // 0099 down to terminal
    bus.mode = 2'b11;
    bus.preval = 8'h00;
    press(1'b0, 1'b1, 3);
    repeat (8) step();
    check("pre0099", dig(), 32'h0099);
    nt = 0;
    press(1'b1, 1'b0, 3);
    wait_run(1'b1, "z_run");
    for (int i = 0; i < 500 && !bus.done; i++) step();
    check("dn_done", bus.done, 1'b1);
    check("dn_zero", dig(), 32'h0000);
    check("dn_ticks", nt, 99);
    check("dn_stop", bus.running, 1'b0);
    press(1'b1, 1'b0, 3);
    repeat (10) step();
    check("done_ign", bus.done, 1'b1);
    check("done_run", bus.running, 1'b0);

    // clear out of DONE, then s+r together
    bus.mode = 2'b00;
    press(1'b0, 1'b1, 3);
    repeat (8) step();
    check("clr_done", bus.done, 1'b0);
    check("clr_dig", dig(), 32'h0000);
    press(1'b1, 1'b0, 3);
    wait_run(1'b1, "sr_start");
    run_ticks(2);
    press(1'b1, 1'b1, 3);
    repeat (6) step();
    check("sr_run", bus.running, 1'b0);
    check("sr_dig", dig(), 32'h0000);
    check("sr_done", bus.done, 1'b0);

    // reset mid-run
    press(1'b1, 1'b0, 3);
    wait_run(1'b1, "rr_run");
    run_ticks(3);
    reset = 1'b1;
    step();
    check("rr_dig", dig(), 32'h0000);
    check("rr_run0", bus.running, 1'b0);
    check("rr_tick", bus.tick, 1'b0);
    reset = 1'b0;
    repeat (3) step();

`ifdef STOPWATCH_LAP_EN
    nt = 0;
    press(1'b1, 1'b0, 3);
    wait_run(1'b1, "lap_run");
    run_ticks(12);
    bus.lap = 1'b1;
    repeat (3) step();
    bus.lap = 1'b0;
    run_ticks(21 - nt);
    check("lap_show", dig(), 32'h0012);
    repeat (3) step();
    bus.lap = 1'b1;
    repeat (3) step();
    bus.lap = 1'b0;
    repeat (2) step();
    check("lap_clr", dig(), 32'h0022);
    check("lap_run1", bus.running, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
